// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core pipeline stages.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One instruction-queue entry: the fetch PC paired with the returned word.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // J/JAL target: the upper nibble comes from the PC of the delay-slot position (pc+4).
  function automatic logic [31:0] j_target(input logic [31:0] pc,
                                           input logic [25:0] instr_index);
    logic [31:0] pc_plus4;
    pc_plus4 = pc + 32'd4;
    return {pc_plus4[31:28], instr_index, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush, used for in-flight PCs and the instruction queue.
module fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [W-1:0]             head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  // Storage and pointers; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues in-order imem requests, remembers the PC of
// every request in flight, queues returned words for decode and handles
// decode-stage jumps and EX-stage redirects by flushing and squashing.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          QDEPTH   = 2,
  parameter int          CNT_W    = $clog2(QDEPTH) + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        AnyStall,
  input  logic        Jump_IDM1,
  input  logic [25:0] JumpTgt_IDM1,
  input  logic        ExRedirect_EX,
  input  logic [31:0] ExRedirectPc_EX,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemGnt,
  input  logic        ImemRspVal,
  input  logic [31:0] ImemRspData,
  output logic [31:0] Pc_IF,
  output logic [31:0] FetchData_IF,
  output logic        InstrVal_IF
);

  localparam int IU_W = CNT_W + 1;

  fetch_entry_t     iq_head;
  fetch_entry_t     iq_wdata;
  logic [31:0]      fpc;
  logic [31:0]      rsp_pc;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] occupancy;
  logic [CNT_W-1:0] squash;
  logic [IU_W-1:0]  in_use;
  logic             pcq_full, pcq_empty, iq_full, iq_empty;
  logic             grant, rsp, head_pop, jump_take, redirect, iq_push;
  logic             unused_bits;

  assign grant     = ImemReq && ImemGnt;
  assign rsp       = ImemRspVal && !pcq_empty;
  assign head_pop  = !iq_empty && !AnyStall;
  assign jump_take = Jump_IDM1 && head_pop;
  assign redirect  = ExRedirect_EX || jump_take;

  // EX wins over a same-cycle jump.
  assign redirect_pc = ExRedirect_EX ? {ExRedirectPc_EX[31:2], 2'b00}
                                     : j_target(iq_head.pc, JumpTgt_IDM1);

  // Responses for squashed requests, or arriving in a redirect cycle, are dropped.
  assign iq_push  = rsp && !redirect && (squash == '0);
  assign iq_wdata = '{pc: rsp_pc, instr: ImemRspData};

  // Every request in flight owns a queue slot. A head leaving this cycle frees
  // its slot before any response to a request issued now can land, which keeps
  // one-cycle memory streaming at one instruction per cycle.
  assign in_use  = IU_W'(outstanding) + IU_W'(occupancy) - IU_W'(head_pop);
  assign ImemReq = !reset && !pcq_full && (in_use < IU_W'(QDEPTH));

  assign ImemAddr     = fpc;
  assign Pc_IF        = iq_head.pc;
  assign FetchData_IF = iq_head.instr;
  assign InstrVal_IF  = !iq_empty;

  assign unused_bits = ^{iq_full, ExRedirectPc_EX[1:0]};

  // Fetch PC: a redirect replaces any pending address, a grant advances it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         fpc <= RESET_PC;
    else if (redirect) fpc <= redirect_pc;
    else if (grant)    fpc <= fpc + 32'd4;
  end

  // Squash count: on redirect, everything still in flight after this cycle is stale.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       squash <= '0;
    else if (redirect)               squash <= outstanding + CNT_W'(grant) - CNT_W'(rsp);
    else if (rsp && squash != '0)    squash <= squash - 1'b1;
  end

  fetch_fifo #(.W(32), .DEPTH(QDEPTH)) u_pc_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (grant),
    .push_data (fpc),
    .pop       (rsp),
    .flush     (1'b0),
    .head_data (rsp_pc),
    .full      (pcq_full),
    .empty     (pcq_empty),
    .count     (outstanding)
  );

  fetch_fifo #(.W(64), .DEPTH(QDEPTH)) u_instr_q (
    .clk       (clk),
    .reset     (reset),
    .push      (iq_push),
    .push_data (iq_wdata),
    .pop       (head_pop),
    .flush     (redirect),
    .head_data (iq_head),
    .full      (iq_full),
    .empty     (iq_empty),
    .count     (occupancy)
  );

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined MIPS core. It sits directly upstream of decode and owns the architectural fetch PC. It issues in-order requests to a variable-latency instruction memory and buffers returned words in a small queue. It presents `Pc_IF`/`FetchData_IF`/`InstrVal_IF` to decode, honours `AnyStall` back-pressure, and redirects on decode-stage jumps and execute-stage branch/JR redirects.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `QDEPTH`, 2: instruction queue entries. Must be ≥ 2 and a power of 2.
- `CNT_W`, $clog2(QDEPTH)+1: width of the occupancy and outstanding counters.

Ports:
- `clk` in 1: sole clock. All state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `AnyStall` in 1: decode cannot accept this cycle.
- `Jump_IDM1` in 1: J/JAL decoded from the current `FetchData_IF`.
- `JumpTgt_IDM1` in 26: instr_index of that jump.
- `ExRedirect_EX` in 1: taken branch or JR resolved in EX.
- `ExRedirectPc_EX` in 32: redirect target.
- `ImemReq` out 1: fetch request valid.
- `ImemAddr` out 32: word-aligned fetch address.
- `ImemGnt` in 1: request accepted this cycle when `ImemReq` is also high.
- `ImemRspVal` in 1: read data valid. Responses return in order, at least 1 cycle after grant.
- `ImemRspData` in 32: instruction word.
- `Pc_IF` out 32: PC of the queue head.
- `FetchData_IF` out 32: instruction at the queue head.
- `InstrVal_IF` out 1: queue head valid.

## Operation
- **Fetch PC (`fpc`).** On a grant, `fpc <= fpc + 4`. `ImemAddr = fpc`, and bits [1:0] are always 0.
- **Issue rule.** `ImemReq = !reset_state && (outstanding + occupancy < QDEPTH)`. Every response is therefore guaranteed a queue slot, and `ImemRspVal` is never back-pressured.
- **In-flight PCs.** The PC of each granted request is pushed into a PC FIFO of depth `QDEPTH`. On each response, the PC FIFO is popped and the pair {pc, data} is written into the instruction queue.
- **Pop.** The queue head is popped when `InstrVal_IF && !AnyStall`.
- **Jump redirect.** Taken when `Jump_IDM1 && InstrVal_IF && !AnyStall`.
  - The jump itself is popped.
  - All younger queue entries are discarded.
  - `fpc <= {Pc_IF[31:28]+carry of (Pc_IF+4), JumpTgt_IDM1, 2'b00}`, i.e. the upper bits come from `Pc_IF+4`.
- **EX redirect.** Taken when `ExRedirect_EX` is high.
  - The entire queue is flushed, including the head.
  - `fpc <= ExRedirectPc_EX`.
  - EX redirect has priority over a jump redirect in the same cycle.
- **Squash on redirect.** `squash <= outstanding`, plus 1 if a grant occurs in the redirect cycle.
  - While `squash != 0`, each response decrements `squash` and is dropped. The PC FIFO is still popped.
  - A response arriving in the redirect cycle itself is dropped and counted against `outstanding`, not `squash`.
- **No delay slots.** Instructions fetched after a taken jump are always discarded.
- **Simultaneous push and pop** in the same cycle leaves occupancy unchanged. The FIFO pointers wrap modulo `QDEPTH`.

## Timing
- **Reset values.**
  - `ImemReq=0`, `ImemAddr=RESET_PC`, `InstrVal_IF=0`, `Pc_IF=0`, `FetchData_IF=0`.
  - Queue, PC FIFO, `outstanding` and `squash` are all cleared.
  - `ImemReq` rises in the first cycle after `reset` deasserts.
- **Response latency.** `ImemRspVal` in cycle N gives `InstrVal_IF` in N+1, because the queue output is registered. There is no bypass.
- **Redirect latency.** A redirect in cycle N gives `ImemAddr` equal to the target in N+1.
  - `InstrVal_IF=0` in N+1, except for the popped jump's successor, which does not exist.
  - The earliest new instruction arrives at N+3 with 1-cycle memory.
- **Request hold.** `ImemAddr` is held stable while `ImemReq && !ImemGnt`. The only exception is a redirect, which replaces the pending request with the new address.
- **Reset mid-operation.** The instruction memory shares `reset`, so no stale responses follow a reset.
- **Back-to-back issue.** Sustains 1 instruction/cycle with `QDEPTH=2` and 1-cycle memory.

## Structure
- Shared package `mips_pkg` holds `RESET_PC_DEFAULT` and the J-target formation helper, which is reused by branch logic.
- One sub-module, `fetch_fifo #(W, DEPTH)`, provides synchronous push/pop, flush, full, empty and count. It is instantiated twice:
  - the PC FIFO, W=32;
  - the instruction queue, W=64.
- Counters `outstanding` and `squash` are `CNT_W` bits wide and must never underflow. The bench checks this with an assertion.

## Test plan
1. **Straight-line fetch.** Reset release, 1-cycle memory, `AnyStall=0` → `ImemAddr` 0,4,8,…; `InstrVal_IF` first high 2 cycles after the first grant; `Pc_IF` increments by 4 every cycle.
2. **Stall.** `AnyStall=1` for 5 cycles with the queue full → `ImemReq=0`; `FetchData_IF`/`Pc_IF` held; no word lost or duplicated after release.
3. **Jump.** Head=J with `JumpTgt=26'h40` at `Pc_IF=0x1000` → next `ImemAddr=0x100`; in-flight word at 0x1008 dropped; next valid `Pc_IF=0x100`.
4. **EX redirect with 2 outstanding and 3-cycle latency.** `ExRedirectPc_EX=0x2000` → both stale responses dropped; first valid `Pc_IF=0x2000`.
5. **EX redirect and jump in the same cycle.** `ExRedirectPc_EX=0x3000`, jump target 0x100 → fetch resumes at 0x3000.
6. **Reset asserted mid-stream with 2 outstanding** → all outputs return to reset values asynchronously; fetch restarts at `RESET_PC`.
